// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage sitting directly upstream of a synchronous instruction memory
// with one-cycle read latency. IFU_PC is combinational and feeds the IMEM
// address, so the word IMEM returns in any cycle is always mem[cur_pc_q].
// Redirects therefore cost zero bubbles. The only bubble is the first cycle
// after reset, when no word has been read yet.
//
// Ports
//   IFU_clk               in   clock, all state updates on rising edge
//   IFU_rst_n             in   synchronous active-low reset
//   IFU_PC                out  next fetch index (IMEM address)
//   IFU_imem_instruction  in   IMEM read data for the index sampled last edge
//   IFU_stall             in   hold the presented instruction
//   IFU_redirect          in   taken branch/jump, kills presented instruction
//   IFU_redirect_target   in   index to fetch on redirect
//   IFU_instruction       out  instruction to decode
//   IFU_instr_PC          out  index of IFU_instruction
//   IFU_instr_PC_plus1    out  IFU_instr_PC + 1 (link value, wraps)
//   IFU_valid             out  IFU_instruction is meaningful
//   IFU_fetch_count       out  number of instructions accepted by decode
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  CNT_WIDTH   = 16
) (
    input  logic                   IFU_clk,
    input  logic                   IFU_rst_n,
    output logic [PC_WIDTH-1:0]    IFU_PC,
    input  logic [INSTR_WIDTH-1:0] IFU_imem_instruction,
    input  logic                   IFU_stall,
    input  logic                   IFU_redirect,
    input  logic [PC_WIDTH-1:0]    IFU_redirect_target,
    output logic [INSTR_WIDTH-1:0] IFU_instruction,
    output logic [PC_WIDTH-1:0]    IFU_instr_PC,
    output logic [PC_WIDTH-1:0]    IFU_instr_PC_plus1,
    output logic                   IFU_valid,
    output logic [CNT_WIDTH-1:0]   IFU_fetch_count
);

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [PC_WIDTH-1:0]  cur_pc_q;
    logic [PC_WIDTH-1:0]  pc_d;
    logic [PC_WIDTH-1:0]  pc_inc;
    logic                 valid_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 accept;

    assign pc_inc = cur_pc_q + PC_ONE;

    // Next fetch index. Redirect beats stall; while valid_q is low the
    // current word has not been read yet, so it is fetched again.
    always_comb begin
        // NOTE: default assignment first so every path drives pc_d and no latch is inferred.
        pc_d = pc_inc;
        if (!IFU_rst_n) begin
            pc_d = RESET_PC;
        end else if (IFU_redirect) begin
            pc_d = IFU_redirect_target;
        end else if (!valid_q || IFU_stall) begin
            pc_d = cur_pc_q;
        end
    end

    // Decode takes the presented word only if nothing holds or kills it.
    assign accept  = valid_q && !IFU_stall && !IFU_redirect;
    assign count_d = accept ? count_q + CNT_ONE : count_q;

    always_ff @(posedge IFU_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!IFU_rst_n) begin
            cur_pc_q <= RESET_PC;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            cur_pc_q <= pc_d;
            valid_q  <= 1'b1;
            count_q  <= count_d;
        end
    end

    assign IFU_PC             = pc_d;
    assign IFU_instruction    = IFU_imem_instruction;
    assign IFU_instr_PC       = cur_pc_q;
    assign IFU_instr_PC_plus1 = pc_inc;
    assign IFU_valid          = valid_q;
    assign IFU_fetch_count    = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A behavioural IMEM holds mem[i] = i.
// The driver applies one cycle of inputs just after each rising edge and
// pushes the hand-computed outputs for that cycle into a queue; a monitor
// pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [7:0]  ifu_pc;
        logic        valid;
        logic [7:0]  ipc;
        logic [7:0]  plus1;
        logic [15:0] cnt;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ifu_pc;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [7:0]  target;
    logic [31:0] instruction;
    logic [7:0]  instr_pc;
    logic [7:0]  instr_pc_plus1;
    logic        valid;
    logic [15:0] fetch_count;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   mon_cyc  = 0;

    always #5 clk = ~clk;

    // IMEM model: one-cycle latency, mem[i] = i.
    always @(posedge clk) imem_rdata <= {24'd0, ifu_pc};

    instr_fetch_unit #(
        .PC_WIDTH   (8),
        .INSTR_WIDTH(32),
        .RESET_PC   (8'd0),
        .CNT_WIDTH  (16)
    ) dut (
        .IFU_clk             (clk),
        .IFU_rst_n           (rst_n),
        .IFU_PC              (ifu_pc),
        .IFU_imem_instruction(imem_rdata),
        .IFU_stall           (stall),
        .IFU_redirect        (redirect),
        .IFU_redirect_target (target),
        .IFU_instruction     (instruction),
        .IFU_instr_PC        (instr_pc),
        .IFU_instr_PC_plus1  (instr_pc_plus1),
        .IFU_valid           (valid),
        .IFU_fetch_count     (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, mon_cyc, act, req);
        end
    endtask

    // One driven cycle with the outputs expected during it.
    task automatic cyc(input logic r, input logic st, input logic rd, input logic [7:0] tgt,
                       input logic [7:0] e_pc, input logic e_v, input logic [7:0] e_ipc,
                       input logic [15:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n    = r;
        stall    = st;
        redirect = rd;
        target   = tgt;
        e.ifu_pc = e_pc;
        e.valid  = e_v;
        e.ipc    = e_ipc;
        e.plus1  = e_ipc + 8'd1;
        e.cnt    = e_cnt;
        e.instr  = {24'd0, e_ipc};
        exp_q.push_back(e);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                mon_cyc++;
                check("ifu_pc",      32'(ifu_pc),         32'(mon_e.ifu_pc));
                check("valid",       32'(valid),          32'(mon_e.valid));
                check("instr_pc",    32'(instr_pc),       32'(mon_e.ipc));
                check("instr_plus1", 32'(instr_pc_plus1), 32'(mon_e.plus1));
                check("fetch_count", 32'(fetch_count),    32'(mon_e.cnt));
                if (mon_e.valid)
                    check("instruction", instruction, mon_e.instr);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        target   = 8'd0;

        // Reset held for three edges, then release and free-run.
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 16'd0);  // bubble
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd1, 1'b1, 8'd0, 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 8'd1, 16'd1);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd3, 1'b1, 8'd2, 16'd2);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 1'b1, 8'd3, 16'd3);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd5, 1'b1, 8'd4, 16'd4);

        // Stall two cycles at PC 5.
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 8'd5, 1'b1, 8'd5, 16'd5);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 8'd5, 1'b1, 8'd5, 16'd5);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd6, 1'b1, 8'd5, 16'd5);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd7, 1'b1, 8'd6, 16'd6);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd8, 1'b1, 8'd7, 16'd7);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd9, 1'b1, 8'd8, 16'd8);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd10, 1'b1, 8'd9, 16'd9);

        // Redirect together with stall at PC 10: redirect wins, PC 10 not counted.
        cyc(1'b1, 1'b1, 1'b1, 8'h40, 8'h40, 1'b1, 8'd10, 16'd10);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h41, 1'b1, 8'h40, 16'd10);

        // Redirect to 0xFE and free-run across the wrap.
        cyc(1'b1, 1'b0, 1'b1, 8'hFE, 8'hFE, 1'b1, 8'h41, 16'd11);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'hFE, 16'd11);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 16'd12);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 8'h00, 16'd13);

        // Self-loop redirect refetches the same word.
        cyc(1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 1'b1, 8'h01, 16'd14);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 8'h01, 16'd14);

        // Reset, then reach PC 20 with count 7 via a redirect.
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h02, 16'd15);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 16'd0);
        for (int k = 0; k < 7; k++)
            cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'(k + 1), 1'b1, 8'(k), 16'(k));
        cyc(1'b1, 1'b0, 1'b1, 8'd20, 8'd20, 1'b1, 8'd7, 16'd7);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 8'd20, 1'b1, 8'd20, 16'd7);

        // Reset asserted mid-stall.
        cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 8'd20, 16'd7);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 16'd0);

        // Refill and run past 65536 accepts so the counter wraps to 0.
        for (int j = 0; j < 65539; j++)
            cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'(j + 1), 1'b1, 8'(j), 16'(j));

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage that sits directly upstream of the synchronous instruction memory (one-cycle read latency, word-addressed, 8-bit index).
- Generates the next fetch index every cycle and tracks the PC of the word IMEM currently presents.
- Presents instruction, PC, PC+1 and a valid flag to decode.
- Handles stall, branch/jump redirect, the reset bubble, and a retired-fetch counter.

Parameters:
- PC_WIDTH, 8, width of the word index (IMEM depth = 2^PC_WIDTH).
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 0, first word index fetched after reset.
- CNT_WIDTH, 16, width of the fetch counter.

Ports:
- IFU_clk  in  1  single clock; all state updates on its rising edge.
- IFU_rst_n  in  1  synchronous, active-low reset.
- IFU_PC  out  PC_WIDTH  combinational next-fetch index; drives the IMEM address input.
- IFU_imem_instruction  in  INSTR_WIDTH  IMEM read data (word at the index sampled last edge).
- IFU_stall  in  1  decode/hazard unit holds the presented instruction.
- IFU_redirect  in  1  taken branch/jump; kills the presented instruction.
- IFU_redirect_target  in  PC_WIDTH  word index to fetch on redirect.
- IFU_instruction  out  INSTR_WIDTH  instruction to decode (= IFU_imem_instruction).
- IFU_instr_PC  out  PC_WIDTH  word index of IFU_instruction (cur_pc register).
- IFU_instr_PC_plus1  out  PC_WIDTH  cur_pc+1, mod 2^PC_WIDTH (link value).
- IFU_valid  out  1  IFU_instruction is meaningful.
- IFU_fetch_count  out  CNT_WIDTH  number of instructions accepted by decode.

Behaviour:
- State: cur_pc (PC_WIDTH), valid_q (1), count_q (CNT_WIDTH).
- Invariant: in any cycle, IFU_imem_instruction = mem[cur_pc], because IMEM sampled IFU_PC at the previous edge and cur_pc <= IFU_PC at that same edge.
- IFU_PC priority, combinational:
  - rst_n = 0 → RESET_PC.
  - IFU_redirect = 1 → IFU_redirect_target.
  - valid_q = 0 → cur_pc (refetch / bubble fill).
  - IFU_stall = 1 → cur_pc.
  - otherwise → cur_pc + 1, wrapping 255→0.
- Every edge: cur_pc <= IFU_PC.
- valid_q:
  - <= 0 while in reset.
  - <= 1 on every non-reset edge.
  - IFU_valid = valid_q.
- Accept: an instruction is accepted when valid_q = 1, IFU_stall = 0 and IFU_redirect = 0. On an accepting edge, count_q <= count_q + 1 (wraps at 2^CNT_WIDTH).
- Redirect:
  - Takes priority over stall.
  - The presented instruction is discarded and not counted.
  - Next cycle presents mem[target] with valid = 1. Zero bubble cycles (IMEM latency is absorbed by the combinational IFU_PC).
- Stall: IFU_PC = cur_pc, so IMEM re-reads the same word. All outputs remain stable, and no count increment occurs.
- Reset (synchronous, any time including mid-stall or mid-redirect):
  - At the edge: cur_pc <= RESET_PC, valid_q <= 0, count_q <= 0.
  - Output reset values: IFU_PC = RESET_PC, IFU_instr_PC = RESET_PC, IFU_instr_PC_plus1 = RESET_PC+1, IFU_valid = 0, IFU_fetch_count = 0.
  - IFU_instruction = IMEM data; it is don't-care while IFU_valid = 0.
- Post-reset latency:
  - First cycle with rst_n = 1: valid = 0, IFU_PC = RESET_PC.
  - Next edge: valid = 1, presenting mem[RESET_PC].
- Wrap-around: cur_pc = 2^PC_WIDTH−1 with no stall/redirect → IFU_PC = 0, and IFU_instr_PC_plus1 = 0.
- Redirect target equal to cur_pc is legal and refetches the same word (self-loop).
- No X propagation: IFU_PC is a pure function of registered state plus IFU_stall, IFU_redirect, IFU_redirect_target and rst_n.

Test Plan:
1. Reset then free-run. Hold rst_n = 0 for 3 edges, release; IMEM holds mem[i] = i.
   - First post-release cycle: IFU_valid = 0.
   - Next edge: IFU_valid = 1, instr_PC = 0, instruction = 0.
   - Afterwards instr_PC advances 1, 2, 3 each edge; IFU_fetch_count = 3 after presenting PC 3.
2. Stall. Stall = 1 for 2 cycles while presenting PC 5.
   - IFU_PC = 5, instruction/PC hold at 5, count does not change.
   - After release: PC 6 on the next edge.
3. Redirect. While presenting PC 10, assert redirect with target 0x40, together with stall = 1.
   - Next cycle: instr_PC = 0x40, valid = 1.
   - PC 10 is not counted; redirect overrides stall.
4. Wrap. Redirect to 0xFE, free-run.
   - instr_PC sequence 0xFE, 0xFF, 0x00; PC_plus1 at 0xFF is 0x00.
5. Mid-operation reset. Assert rst_n = 0 during a stall at PC 20 with count = 7.
   - After that edge: valid = 0, count = 0, instr_PC = 0, IFU_PC = 0.
   - Refill per scenario 1.
6. Counter wrap. Preload via 65,536 accepts with CNT_WIDTH = 16 → count returns to 0 with no glitch on valid or PC.
